// File: rtl/disp_upd_sched.sv
// rtl/disp_upd_sched.sv - frame-synchronous round-robin scheduler for renderer display data
// Captures a winner in idle, commits its word at a frame boundary, then holds it for a frame count.
`timescale 1ns/1ps
module disp_upd_sched #(
   parameter int                 C_REQ_N       = 4,
   parameter int                 C_DAT_W       = 33,
   parameter int                 C_HOLD_FRAMES = 30,
   parameter logic [C_DAT_W-1:0] C_RST_DAT     = '1
) (
   input  logic                       CK_i,
   input  logic                       ARST_i,
   input  logic                       FRAME_EE_i,
   input  logic                       FREEZE_i,
   input  logic [C_REQ_N-1:0]         REQs_i,
   input  logic [C_REQ_N*C_DAT_W-1:0] DATss_i,
   output logic [C_REQ_N-1:0]         ACKs_o,
   output logic [C_DAT_W-1:0]         DISP_DATss_o,
   output logic [2:0]                 SRC_o,
   output logic                       UPD_EE_o,
   output logic                       BUSY_o
);

   localparam int PTR_W   = $clog2(C_REQ_N);
   localparam int CNT_RAW = $clog2(C_HOLD_FRAMES + 1);
   localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(C_HOLD_FRAMES);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_HOLD} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [C_DAT_W-1:0]   pend_dat_q, pend_dat_d;
   logic [2:0]           pend_src_q, pend_src_d;
   logic [C_DAT_W-1:0]   disp_q, disp_d;
   logic [2:0]           src_q, src_d;
   logic [C_REQ_N-1:0]   ack_q, ack_d;
   logic                 upd_q, upd_d;
   logic                 busy_q, busy_d;

   logic                 found;
   logic [PTR_W-1:0]     winner;
   logic [PTR_W-1:0]     scan_idx;
   logic                 frame_ok;

   assign frame_ok = FRAME_EE_i & ~FREEZE_i;

   // Round-robin search starting at the pointer, wrapping past the last requester
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int i = 0; i < C_REQ_N; i++) begin
         scan_idx = PTR_W'((int'(ptr_q) + i) % C_REQ_N);
         if (!found && REQs_i[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
      end
   end

   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_PEND;
            end
         end
         S_PEND: begin
            if (frame_ok) begin
               state_d = (C_HOLD_FRAMES == 0) ? S_IDLE : S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      pend_dat_d = pend_dat_q;
      pend_src_d = pend_src_q;
      disp_d     = disp_q;
      src_d      = src_q;
      ack_d      = '0;
      upd_d      = 1'b0;
      busy_d     = (state_d != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (found) begin
               pend_dat_d     = DATss_i[int'(winner)*C_DAT_W +: C_DAT_W];
               pend_src_d     = 3'(winner);
               ack_d[winner]  = 1'b1;
               ptr_d          = (winner == PTR_W'(C_REQ_N - 1)) ? '0 : winner + 1'b1;
            end
         end
         S_PEND: begin
            if (frame_ok) begin
               disp_d = pend_dat_q;
               src_d  = pend_src_q;
               upd_d  = 1'b1;
               cnt_d  = HOLD_INIT;
            end
         end
         S_HOLD: begin
            if (cnt_q != '0 && frame_ok) begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         ptr_q      <= '0;
         cnt_q      <= '0;
         pend_dat_q <= '0;
         pend_src_q <= '0;
         disp_q     <= C_RST_DAT;
         src_q      <= '0;
         ack_q      <= '0;
         upd_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         pend_dat_q <= pend_dat_d;
         pend_src_q <= pend_src_d;
         disp_q     <= disp_d;
         src_q      <= src_d;
         ack_q      <= ack_d;
         upd_q      <= upd_d;
         busy_q     <= busy_d;
      end
   end

   assign ACKs_o       = ack_q;
   assign DISP_DATss_o = disp_q;
   assign SRC_o        = src_q;
   assign UPD_EE_o     = upd_q;
   assign BUSY_o       = busy_q;

endmodule

// File: tb/tb_disp_upd_sched.sv
// tb/tb_disp_upd_sched.sv - self-checking bench for disp_upd_sched
// Two instances: hold of 2 frames (dut_a) and no hold (dut_b), sharing all inputs.
`timescale 1ns/1ps
module tb_disp_upd_sched;

   localparam logic [32:0] ONES = 33'h1_FFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         frame = 1'b0;
   logic         freeze = 1'b0;
   logic [3:0]   req = '0;
   logic [131:0] dat = '0;

   logic [3:0]   ack_a, ack_b;
   logic [32:0]  disp_a, disp_b;
   logic [2:0]   src_a, src_b;
   logic         upd_a, upd_b, busy_a, busy_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   disp_upd_sched #(.C_REQ_N(4), .C_DAT_W(33), .C_HOLD_FRAMES(2)) dut_a (
      .CK_i(clk), .ARST_i(rst), .FRAME_EE_i(frame), .FREEZE_i(freeze),
      .REQs_i(req), .DATss_i(dat), .ACKs_o(ack_a), .DISP_DATss_o(disp_a),
      .SRC_o(src_a), .UPD_EE_o(upd_a), .BUSY_o(busy_a)
   );

   disp_upd_sched #(.C_REQ_N(4), .C_DAT_W(33), .C_HOLD_FRAMES(0)) dut_b (
      .CK_i(clk), .ARST_i(rst), .FRAME_EE_i(frame), .FREEZE_i(freeze),
      .REQs_i(req), .DATss_i(dat), .ACKs_o(ack_b), .DISP_DATss_o(disp_b),
      .SRC_o(src_b), .UPD_EE_o(upd_b), .BUSY_o(busy_b)
   );

   // Reference model: index 0 tracks dut_a (hold 2), index 1 tracks dut_b (hold 0)
   int          m_ptr[2];
   bit          m_pend[2];
   bit          m_hold[2];
   int          m_left[2];
   logic [32:0] m_pword[2];
   int          m_pidx[2];
   logic [32:0] m_disp[2];
   int          m_src[2];
   logic [3:0]  m_ack[2];
   bit          m_upd[2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req = '0; frame = 1'b0; freeze = 1'b0; dat = '0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_ptr[m] = 0; m_pend[m] = 0; m_hold[m] = 0; m_left[m] = 0;
         m_pword[m] = '0; m_pidx[m] = 0; m_disp[m] = ONES; m_src[m] = 0;
         m_ack[m] = '0; m_upd[m] = 0;
      end
   endtask

   // Advances one model by one clock edge using the inputs currently applied
   task automatic model_edge(input int m, input int hold);
      bit got;
      int w;
      m_ack[m] = '0;
      m_upd[m] = 0;
      if (m_pend[m]) begin
         if (frame && !freeze) begin
            m_disp[m] = m_pword[m];
            m_src[m]  = m_pidx[m];
            m_upd[m]  = 1;
            m_pend[m] = 0;
            if (hold > 0) begin
               m_hold[m] = 1;
               m_left[m] = hold;
            end
         end
      end else if (m_hold[m]) begin
         if (m_left[m] == 0) m_hold[m] = 0;
         else if (frame && !freeze) m_left[m] = m_left[m] - 1;
      end else if (req != 0) begin
         got = 0;
         w = 0;
         for (int k = 0; k < 4; k++) begin
            if (!got && req[(m_ptr[m] + k) % 4]) begin
               got = 1;
               w = (m_ptr[m] + k) % 4;
            end
         end
         m_pword[m] = dat[w*33 +: 33];
         m_pidx[m]  = w;
         m_ack[m]   = 4'(1 << w);
         m_ptr[m]   = (w + 1) % 4;
         m_pend[m]  = 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_tests++;
      if (disp_a !== ONES || ack_a !== 4'b0 || src_a !== 3'd0 || upd_a !== 1'b0 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: disp=%h ack=%b src=%0d upd=%b busy=%b, want disp=%h ack=0 src=0 upd=0 busy=0",
                  disp_a, ack_a, src_a, upd_a, busy_a, ONES);
      end
      tick();
      rst = 1'b0;
      req = 4'b0001;
      dat[0 +: 33] = 33'h0_1234_5678;
      tick();
      n_tests++;
      if (ack_a !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_pre_ack: ack=%b want 0001", ack_a);
      end
      req = '0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (disp_a !== ONES || ack_a !== 4'b0 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_pend: disp=%h ack=%b busy=%b, want disp=%h ack=0 busy=0",
                  disp_a, ack_a, busy_a, ONES);
      end
      rst = 1'b0;
      frame = 1'b1;
      tick();
      frame = 1'b0;
      n_tests++;
      if (upd_a !== 1'b0 || disp_a !== ONES) begin
         n_fail++;
         $display("FAIL reset_discard: upd=%b disp=%h, want upd=0 disp=%h", upd_a, disp_a, ONES);
      end
   endtask

   task automatic test_hold();
      apply_reset();
      req = 4'b0010;
      dat[33 +: 33] = 33'h0_0000_00A5;
      tick();
      n_tests++;
      if (ack_a !== 4'b0010) begin
         n_fail++;
         $display("FAIL hold_ack: ack=%b want 0010", ack_a);
      end
      req = '0;
      tick();
      frame = 1'b1;
      tick();
      frame = 1'b0;
      n_tests++;
      if (disp_a !== 33'h0_0000_00A5 || src_a !== 3'd1 || upd_a !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_commit: disp=%h src=%0d upd=%b, want disp=000000a5 src=1 upd=1",
                  disp_a, src_a, upd_a);
      end
      for (int f = 0; f < 2; f++) begin
         tick();
         frame = 1'b1;
         tick();
         frame = 1'b0;
         n_tests++;
         if (busy_a !== 1'b1 || upd_a !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_busy_%0d: busy=%b upd=%b, want busy=1 upd=0", f, busy_a, upd_a);
         end
      end
      tick();
      n_tests++;
      if (busy_a !== 1'b0 || disp_a !== 33'h0_0000_00A5) begin
         n_fail++;
         $display("FAIL hold_release: busy=%b disp=%h, want busy=0 disp=000000a5", busy_a, disp_a);
      end
   endtask

   task automatic test_round_robin();
      int exp_w;
      apply_reset();
      for (int k = 0; k < 4; k++) dat[k*33 +: 33] = 33'(33'h1_0000_0100 + k);
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         exp_w = g % 4;
         tick();
         n_tests++;
         if (ack_b !== 4'(1 << exp_w)) begin
            n_fail++;
            $display("FAIL rr_grant_%0d: ack=%b want %b", g, ack_b, 4'(1 << exp_w));
         end
         frame = 1'b1;
         tick();
         frame = 1'b0;
         n_tests++;
         if (upd_b !== 1'b1 || src_b !== 3'(exp_w) || disp_b !== 33'(33'h1_0000_0100 + exp_w) || ack_b !== 4'b0) begin
            n_fail++;
            $display("FAIL rr_commit_%0d: upd=%b src=%0d disp=%h ack=%b, want upd=1 src=%0d ack=0",
                     g, upd_b, src_b, disp_b, ack_b, exp_w);
         end
      end
      req = '0;
   endtask

   task automatic test_same_cycle();
      apply_reset();
      req = 4'b0100;
      dat[66 +: 33] = 33'h1_0BAD_CAFE;
      frame = 1'b1;
      tick();
      n_tests++;
      if (ack_a !== 4'b0100 || upd_a !== 1'b0 || disp_a !== ONES) begin
         n_fail++;
         $display("FAIL same_cycle_capture: ack=%b upd=%b disp=%h, want ack=0100 upd=0 disp=%h",
                  ack_a, upd_a, disp_a, ONES);
      end
      req = '0;
      frame = 1'b0;
      tick();
      frame = 1'b1;
      tick();
      frame = 1'b0;
      n_tests++;
      if (upd_a !== 1'b1 || disp_a !== 33'h1_0BAD_CAFE || src_a !== 3'd2) begin
         n_fail++;
         $display("FAIL same_cycle_commit: upd=%b disp=%h src=%0d, want upd=1 disp=10badcafe src=2",
                  upd_a, disp_a, src_a);
      end
   endtask

   task automatic test_freeze();
      apply_reset();
      req = 4'b0001;
      dat[0 +: 33] = 33'h0_5A5A_0F0F;
      tick();
      req = '0;
      freeze = 1'b1;
      for (int f = 0; f < 3; f++) begin
         tick();
         frame = 1'b1;
         tick();
         frame = 1'b0;
         n_tests++;
         if (upd_a !== 1'b0 || disp_a !== ONES || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze_hold_%0d: upd=%b disp=%h busy=%b, want upd=0 disp=%h busy=1",
                     f, upd_a, disp_a, busy_a, ONES);
         end
      end
      freeze = 1'b0;
      tick();
      frame = 1'b1;
      tick();
      frame = 1'b0;
      n_tests++;
      if (upd_a !== 1'b1 || disp_a !== 33'h0_5A5A_0F0F) begin
         n_fail++;
         $display("FAIL freeze_release: upd=%b disp=%h, want upd=1 disp=05a5a0f0f", upd_a, disp_a);
      end
   endtask

   task automatic test_withdraw();
      apply_reset();
      req = 4'b0010;
      tick();
      req = '0;
      frame = 1'b1;
      tick();
      frame = 1'b0;
      req = 4'b1000;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_tests++;
         if (ack_a !== 4'b0) begin
            n_fail++;
            $display("FAIL withdraw_no_ack_%0d: ack=%b want 0000", c, ack_a);
         end
      end
      req = '0;
      for (int f = 0; f < 2; f++) begin
         frame = 1'b1;
         tick();
         frame = 1'b0;
         tick();
      end
      req = 4'b1001;
      tick();
      n_tests++;
      if (ack_a !== 4'b1000) begin
         n_fail++;
         $display("FAIL withdraw_ptr: ack=%b want 1000", ack_a);
      end
      req = '0;
   endtask

   task automatic test_random();
      logic [63:0] r64;
      int          shown;
      logic [44:0] got_v, exp_v;
      apply_reset();
      model_reset();
      shown = 0;
      for (int c = 0; c < 600; c++) begin
         req    = 4'($urandom_range(0, 15));
         frame  = ($urandom_range(0, 3) == 0);
         freeze = ($urandom_range(0, 7) == 0);
         for (int k = 0; k < 4; k++) begin
            r64 = {$urandom(), $urandom()};
            dat[k*33 +: 33] = r64[32:0];
         end
         model_edge(0, 2);
         model_edge(1, 0);
         tick();
         for (int m = 0; m < 2; m++) begin
            if (m == 0) got_v = {ack_a, disp_a, src_a, upd_a, busy_a};
            else        got_v = {ack_b, disp_b, src_b, upd_b, busy_b};
            exp_v = {m_ack[m], m_disp[m], 3'(m_src[m]), m_upd[m], (m_pend[m] | m_hold[m])};
            n_tests++;
            if (got_v !== exp_v) begin
               n_fail++;
               if (shown < 10) begin
                  shown++;
                  $display("FAIL random_c%0d_dut%0d: {ack,disp,src,upd,busy}=%h want %h", c, m, got_v, exp_v);
               end
            end
         end
      end
      req = '0; frame = 1'b0; freeze = 1'b0;
   endtask

   initial begin
      test_reset();
      test_hold();
      test_round_robin();
      test_same_cycle();
      test_freeze();
      test_withdraw();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/disp_upd_sched.md
Name: disp_upd_sched

Overview:
Frame-synchronous scheduler that shares the 33-bit display-data input of the 5x7 font NTSC renderer between several requesters, e.g. LFSR pattern, time-stamp bus and host writes. It arbitrates round-robin and captures the winner's word. The captured word is committed to the renderer only at the frame boundary, so there is no mid-frame tearing. It then holds that source on screen for a minimum number of frames before granting again. It sits between the requesters and the renderer's display-data port in the FPGA top layer.

Parameters:
C_REQ_N, 4, number of requesters (2..8)
C_DAT_W, 33, display-data word width
C_HOLD_FRAMES, 30, minimum frames a committed word stays displayed (0 = no hold)
C_RST_DAT, all ones (33'h1_FFFF_FFFF), DISP_DATss_o value after reset

Ports:
CK_i  in  1  system clock
ARST_i  in  1  asynchronous reset, active high
FRAME_EE_i  in  1  one-CK pulse at start of vertical blanking
FREEZE_i  in  1  1 = suppress commits and freeze the hold counter
REQs_i  in  C_REQ_N  per-requester request level
DATss_i  in  C_REQ_N*C_DAT_W  packed request data; requester k uses bits [k*C_DAT_W +: C_DAT_W]
ACKs_o  out  C_REQ_N  one-hot one-CK grant/capture acknowledge
DISP_DATss_o  out  C_DAT_W  word driven to the renderer
SRC_o  out  3  index of the requester whose word is displayed
UPD_EE_o  out  1  one-CK pulse on the cycle DISP_DATss_o changes
BUSY_o  out  1  1 when state is not S_IDLE

Behaviour:
- Reset (ARST_i=1, async), all outputs registered:
  - state=S_IDLE, round-robin pointer PTR=0, hold counter=0
  - ACKs_o=0, DISP_DATss_o=C_RST_DAT, SRC_o=0, UPD_EE_o=0, BUSY_o=0
  - any pending word is discarded; no ACK is issued for it.
- States: S_IDLE, S_PEND, S_HOLD.
- S_IDLE, any REQs_i bit high at edge n:
  - winner = first set bit searching upward from PTR with wrap-around
  - at edge n: capture the winner's slice into PEND_DAT and its index into PEND_SRC
  - ACKs_o[winner]=1 for exactly the cycle after edge n (1-cycle latency)
  - PTR <= winner+1 mod C_REQ_N; state -> S_PEND.
- Requester handshake:
  - keep REQ and data stable until ACK, then drop REQ within one cycle
  - REQ still high in the cycle after ACK is treated as a new request, but it is only evaluated once back in S_IDLE
  - REQ dropped before ACK = request withdrawn; no penalty.
- S_PEND, FRAME_EE_i=1 and FREEZE_i=0:
  - DISP_DATss_o <= PEND_DAT, SRC_o <= PEND_SRC, UPD_EE_o=1 for one cycle
  - hold counter <= C_HOLD_FRAMES
  - state -> S_HOLD, or -> S_IDLE if C_HOLD_FRAMES=0.
- S_PEND, FREEZE_i=1: FRAME_EE_i is ignored; the word stays pending indefinitely.
- S_HOLD:
  - each FRAME_EE_i with FREEZE_i=0 decrements the counter
  - when the counter is 0, state -> S_IDLE on the next edge; no extra frame is needed
  - the word is therefore displayed for exactly C_HOLD_FRAMES full frame boundaries after commit.
- Simultaneous events:
  - REQ arriving in S_IDLE together with FRAME_EE_i: capture only, commit at the next FRAME_EE_i (no same-frame bypass)
  - FRAME_EE_i in S_IDLE: ignored.
- Arbitration happens only in S_IDLE; requests during S_PEND/S_HOLD wait and are not ACKed.
- Hold counter width = clog2(C_HOLD_FRAMES+1), minimum 1 bit.
- SRC_o is 3 bits wide regardless of C_REQ_N; the upper bits are 0.
- DISP_DATss_o changes only on UPD_EE_o cycles.

Test Plan:
- Reset mid-S_PEND (word 33'h0_1234_5678 pending) -> DISP_DATss_o=33'h1_FFFF_FFFF, ACKs_o=0, BUSY_o=0 immediately; the next FRAME_EE_i produces no UPD_EE_o.
- C_HOLD_FRAMES=2; REQ[1] with 33'h0_0000_00A5 -> ACKs_o=4'b0010 one cycle later; at the next FRAME_EE_i, DISP_DATss_o=0_0000_00A5, SRC_o=1, UPD_EE_o pulse; BUSY_o falls after 2 further FRAME_EE_i pulses.
- All four REQs held high continuously, C_HOLD_FRAMES=0 -> grant order 0,1,2,3,0, one grant per frame; no requester is granted twice in a row.
- REQ[2] and FRAME_EE_i in the same cycle while in S_IDLE -> ACKs_o[2] pulses; the commit occurs only at the following FRAME_EE_i.
- FREEZE_i=1 while in S_PEND over 3 FRAME_EE_i pulses -> no UPD_EE_o and DISP_DATss_o unchanged; release FREEZE_i -> commit on the next FRAME_EE_i.
- REQ[3] raised then dropped before a grant, while S_HOLD blocks arbitration -> no ACKs_o[3] and PTR unchanged.
